fidb_bus_controller: RTL and testbench
======================================

Name: fidb_bus_controller

Overview:
- Arbitrates and sequences the 16-bit bidirectional bus driver between the internal FIDBO/XFIDBI buses and the external XFIDB bus.
- Shares the driver between NREQ requesters using round-robin arbitration.
- Generates the driver's direction (EN) and test/drive-enable (TN) controls.
- Inserts bus turnaround cycles when the transfer direction changes, latches write data, and captures read data.

Parameters:
NREQ, 3, number of requesters (1..8)
TURN_CYCLES, 1, idle cycles inserted on direction change (0..7; 0 = no turnaround)
HOLD_CYCLES, 2, cycles one transfer occupies the bus (1..15)

Ports:
clk  input  1  system clock; all logic rising-edge
reset  input  1  synchronous reset, active-high
req  input  NREQ  per-requester transfer request, level
wr  input  NREQ  per-requester direction: 1 = write (drive XFIDB), 0 = read
wdata  input  16*NREQ  write data; requester i occupies bits [16i+15:16i]
gnt  output  NREQ  one-hot grant, high during XFER of the owning requester
done  output  NREQ  one-cycle completion pulse to the owning requester
rdata  output  16  last captured read data
drv_en  output  1  to driver EN: 0 = A to IO (drive out), 1 = IO to ZI (receive)
drv_tn  output  1  to driver TN: 1 enables the IO output
drv_a  output  16  to driver A input (latched write data)
drv_zi  input  16  from driver ZI output
busy  output  1  high whenever state is not IDLE

Behaviour:
- Reset values: gnt=0, done=0, rdata=0, drv_en=1, drv_tn=0, drv_a=0, busy=0, state=IDLE, last_dir=read, rr_ptr=0.
- Reset is synchronous. Asserting reset mid-transfer aborts the transfer: next cycle has reset values, no done pulse, and drv_tn drops immediately at that edge.
- Bus-idle condition (IDLE, TURN): drv_en=1 and drv_tn=0. The bus is never driven outside a write XFER.
- States: IDLE, TURN, XFER. All outputs are registered.
- IDLE:
  - If any req bit is high, select the winner as the first set bit searching from rr_ptr upward, wrapping modulo NREQ.
  - Latch the winner index, its wr bit as cur_dir, and its wdata slice into drv_a (write only; drv_a holds its old value for reads).
  - If cur_dir != last_dir and TURN_CYCLES>0, go to TURN. Otherwise go to XFER.
  - If no req is high, stay in IDLE.
- TURN: stay exactly TURN_CYCLES cycles with gnt=0, then go to XFER.
- XFER:
  - Lasts exactly HOLD_CYCLES cycles. gnt[winner]=1 throughout.
  - Write: drv_en=0, drv_tn=1, drv_a stable at the value latched at grant; wdata changes are ignored.
  - Read: drv_en=1, drv_tn=0. At the end of the final XFER cycle, rdata <= drv_zi.
  - After the final cycle go to IDLE. In that IDLE cycle: done[winner]=1, gnt=0, last_dir=cur_dir, rr_ptr=(winner+1) mod NREQ, and arbitration for the next request runs in the same cycle.
- Latency:
  - Same direction: req sampled at cycle t, XFER at t+1..t+HOLD_CYCLES, done at t+HOLD_CYCLES+1.
  - Direction change: add TURN_CYCLES.
- Requesters hold req until done. Dropping req mid-transfer does not abort it; the transfer completes and done still pulses. A req still high in the done cycle re-arbitrates at lowest round-robin priority.
- Simultaneous requests: exactly one grant. The gnt vector is never multi-hot.
- At most one done bit is high in any cycle. done and gnt are never both high for the same requester.
- rdata holds its value until the next read completes. Writes do not change it.

Test Plan:
- Reset, then req=3'b001, wr=1, wdata0=16'hA5A5 (last_dir=read, TURN_CYCLES=1): 1 TURN cycle, then 2 XFER cycles with drv_en=0, drv_tn=1, drv_a=A5A5, gnt=001; done=001 at t+4.
- Read by requester 1 with drv_zi=16'h1234 immediately after the write: TURN inserted, XFER with drv_en=1, drv_tn=0; rdata=1234 in the done cycle.
- req=3'b111 held continuously, all read: grants in order 0,1,2,0; each XFER is 2 cycles, separated by one IDLE/done cycle; no TURN cycles.
- Requester 2 writes 16'hBEEF and changes wdata to 16'h0000 during XFER: drv_a stays BEEF. req dropped in XFER cycle 1: done still pulses.
- reset asserted in the first XFER cycle of a write: next cycle drv_tn=0, drv_en=1, gnt=0, no done; a fresh req after reset is served from rr_ptr=0.
- TURN_CYCLES=0 with alternating write/read requests: no TURN state; each transfer spans HOLD_CYCLES+1 cycles including done.

Source files
------------

// File: rtl/fidb_bus_controller.sv
// +------------------------------------------------------------------------+
// | fidb_bus_controller                                                    |
// | Round-robin sequencer for the shared 16-bit XFIDB bidirectional driver |
// | Rev 1.0 - initial release                                              |
// +------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module fidb_bus_controller #(
  parameter int NREQ        = 3,
  parameter int TURN_CYCLES = 1,
  parameter int HOLD_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      wr,
  input  logic [16*NREQ-1:0]   wdata,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      done,
  output logic [15:0]          rdata,
  output logic                 drv_en,
  output logic                 drv_tn,
  output logic [15:0]          drv_a,
  input  logic [15:0]          drv_zi,
  output logic                 busy
);

  localparam int         IDXW        = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_TURN      = 2'd1;
  localparam logic [1:0] S_XFER      = 2'd2;
  localparam logic [3:0] C_HOLD_LAST = 4'(HOLD_CYCLES - 1);
  localparam logic [3:0] C_TURN_LAST = 4'(TURN_CYCLES - 1);

  logic [1:0]      state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [IDXW-1:0] win_q, win_d;
  logic [IDXW-1:0] rr_ptr_q, rr_ptr_d;
  logic            cur_dir_q, cur_dir_d;
  logic            last_dir_q, last_dir_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] done_q, done_d;
  logic [15:0]     rdata_q, rdata_d;
  logic [15:0]     drv_a_q, drv_a_d;
  logic            drv_en_q, drv_en_d;
  logic            drv_tn_q, drv_tn_d;
  logic            busy_q, busy_d;

  logic            arb_valid;
  logic [IDXW-1:0] arb_idx;
  logic            xfer_last;
  logic [15:0]     wslice [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
    assign wslice[gi] = wdata[16*gi +: 16];
  end

  // First requester at or after rr_ptr, wrapping modulo NREQ.
  always_comb begin
    int idx;
    arb_valid = 1'b0;
    arb_idx   = '0;
    idx       = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!arb_valid && req[idx]) begin
        arb_valid = 1'b1;
        arb_idx   = IDXW'(idx);
      end
    end
  end

  assign xfer_last = (state_q == S_XFER) && (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      win_q      <= '0;
      rr_ptr_q   <= '0;
      cur_dir_q  <= 1'b0;
      last_dir_q <= 1'b0;
      gnt_q      <= '0;
      done_q     <= '0;
      rdata_q    <= '0;
      drv_a_q    <= '0;
      drv_en_q   <= 1'b1;
      drv_tn_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      win_q      <= win_d;
      rr_ptr_q   <= rr_ptr_d;
      cur_dir_q  <= cur_dir_d;
      last_dir_q <= last_dir_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      rdata_q    <= rdata_d;
      drv_a_q    <= drv_a_d;
      drv_en_q   <= drv_en_d;
      drv_tn_q   <= drv_tn_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    win_d      = win_q;
    rr_ptr_d   = rr_ptr_q;
    cur_dir_d  = cur_dir_q;
    last_dir_d = last_dir_q;
    case (state_q)
      S_IDLE: begin
        if (arb_valid) begin
          win_d     = arb_idx;
          cur_dir_d = wr[arb_idx];
          if ((wr[arb_idx] != last_dir_q) && (TURN_CYCLES > 0)) begin
            state_d = S_TURN;
            cnt_d   = C_TURN_LAST;
          end else begin
            state_d = S_XFER;
            cnt_d   = C_HOLD_LAST;
          end
        end
      end
      S_TURN: begin
        if (cnt_q == '0) begin
          state_d = S_XFER;
          cnt_d   = C_HOLD_LAST;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_XFER: begin
        if (cnt_q == '0) begin
          state_d    = S_IDLE;
          last_dir_d = cur_dir_q;
          rr_ptr_d   = (win_q == IDXW'(NREQ - 1)) ? '0 : win_q + 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so every port comes straight off a flop.
  always_comb begin
    gnt_d  = '0;
    done_d = '0;
    for (int i = 0; i < NREQ; i++) begin
      gnt_d[i]  = (state_d == S_XFER) && (win_d == IDXW'(i));
      done_d[i] = xfer_last && (win_q == IDXW'(i));
    end
    drv_tn_d = (state_d == S_XFER) && cur_dir_d;
    drv_en_d = !drv_tn_d;
    busy_d   = (state_d != S_IDLE);
    drv_a_d  = drv_a_q;
    if ((state_q == S_IDLE) && arb_valid && wr[arb_idx]) drv_a_d = wslice[arb_idx];
    rdata_d = rdata_q;
    if (xfer_last && !cur_dir_q) rdata_d = drv_zi;
  end

  assign gnt    = gnt_q;
  assign done   = done_q;
  assign rdata  = rdata_q;
  assign drv_a  = drv_a_q;
  assign drv_en = drv_en_q;
  assign drv_tn = drv_tn_q;
  assign busy   = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_fidb_bus_controller.sv
// +------------------------------------------------------------------------+
// | tb_fidb_bus_controller                                                 |
// | Bench for fidb_bus_controller with a transaction-schedule model        |
// | Rev 1.0 - initial release                                              |
// +------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_fidb_bus_controller;

  localparam int NREQ = 3;
  localparam int HOLD = 2;

  logic              clk;
  logic              reset;
  logic [NREQ-1:0]   req, wr;
  logic [16*NREQ-1:0] wdata;
  logic [15:0]       drv_zi;

  logic [NREQ-1:0] gnt_a, done_a, gnt_b, done_b;
  logic [15:0]     rdata_a, drv_a_a, rdata_b, drv_a_b;
  logic            drv_en_a, drv_tn_a, busy_a, drv_en_b, drv_tn_b, busy_b;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  fidb_bus_controller #(.NREQ(NREQ), .TURN_CYCLES(1), .HOLD_CYCLES(HOLD)) dut_a (
    .clk(clk), .reset(reset), .req(req), .wr(wr), .wdata(wdata),
    .gnt(gnt_a), .done(done_a), .rdata(rdata_a), .drv_en(drv_en_a),
    .drv_tn(drv_tn_a), .drv_a(drv_a_a), .drv_zi(drv_zi), .busy(busy_a)
  );

  fidb_bus_controller #(.NREQ(NREQ), .TURN_CYCLES(0), .HOLD_CYCLES(HOLD)) dut_b (
    .clk(clk), .reset(reset), .req(req), .wr(wr), .wdata(wdata),
    .gnt(gnt_b), .done(done_b), .rdata(rdata_b), .drv_en(drv_en_b),
    .drv_tn(drv_tn_b), .drv_a(drv_a_b), .drv_zi(drv_zi), .busy(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model tracks each transfer as a schedule of absolute cycle numbers.
  typedef struct {
    int          free_c;
    int          xs;
    int          xe;
    int          done_c;
    int          w;
    int          done_w;
    bit          dir;
    bit          last_dir;
    int          ptr;
    logic [15:0] drv_a;
    logic [15:0] rdata;
  } model_t;

  model_t m_a, m_b;

  function automatic model_t model_reset(input int c);
    model_t n;
    n.free_c = c + 1; n.xs = -10; n.xe = -10; n.done_c = -10;
    n.w = 0; n.done_w = 0; n.dir = 1'b0; n.last_dir = 1'b0; n.ptr = 0;
    n.drv_a = 16'h0; n.rdata = 16'h0;
    return n;
  endfunction

  function automatic model_t mstep(input model_t m, input int turn, input int c,
                                   input logic rst, input logic [NREQ-1:0] rq,
                                   input logic [NREQ-1:0] dirs,
                                   input logic [16*NREQ-1:0] wd, input logic [15:0] zi);
    model_t n;
    bit     found;
    int     tc;
    n = m;
    if (rst) return model_reset(c);
    if ((c == m.xe) && !m.dir) n.rdata = zi;
    if (c >= m.free_c) begin
      found = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
        if (!found && rq[(m.ptr + k) % NREQ]) begin
          found = 1'b1;
          n.w   = (m.ptr + k) % NREQ;
        end
      end
      if (found) begin
        n.dir      = dirs[n.w];
        tc         = (n.dir != m.last_dir) ? turn : 0;
        n.xs       = c + 1 + tc;
        n.xe       = c + tc + HOLD;
        n.free_c   = n.xe + 1;
        n.done_c   = n.free_c;
        n.done_w   = n.w;
        n.last_dir = n.dir;
        n.ptr      = (n.w + 1) % NREQ;
        if (n.dir) n.drv_a = wd[16*n.w +: 16];
      end else begin
        n.free_c = c + 1;
      end
    end
    return n;
  endfunction

  function automatic logic [NREQ-1:0] oh(input int i);
    logic [NREQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_dut(input string nm, input model_t m,
                           input logic [NREQ-1:0] g, input logic [NREQ-1:0] d,
                           input logic [15:0] rd, input logic en, input logic tn,
                           input logic [15:0] a, input logic bz);
    logic inx;
    inx = (cyc >= m.xs) && (cyc <= m.xe);
    chk({nm, ".gnt"},    g,  inx ? oh(m.w) : '0);
    chk({nm, ".done"},   d,  (cyc == m.done_c) ? oh(m.done_w) : '0);
    chk({nm, ".drv_tn"}, tn, inx && m.dir);
    chk({nm, ".drv_en"}, en, !(inx && m.dir));
    chk({nm, ".drv_a"},  a,  m.drv_a);
    chk({nm, ".rdata"},  rd, m.rdata);
    chk({nm, ".busy"},   bz, cyc < m.free_c);
    chk({nm, ".excl"},   $onehot0(g) && $onehot0(d) && ((g & d) == '0), 1'b1);
  endtask

  task automatic tick();
    m_a = mstep(m_a, 1, cyc, reset, req, wr, wdata, drv_zi);
    m_b = mstep(m_b, 0, cyc, reset, req, wr, wdata, drv_zi);
    @(posedge clk);
    cyc++;
    #1;
    check_dut("A", m_a, gnt_a, done_a, rdata_a, drv_en_a, drv_tn_a, drv_a_a, busy_a);
    check_dut("B", m_b, gnt_b, done_b, rdata_b, drv_en_b, drv_tn_b, drv_a_b, busy_b);
  endtask

  initial begin
    m_a = model_reset(0);
    m_b = model_reset(0);
    reset = 1'b1; req = '0; wr = '0; wdata = '0; drv_zi = '0;
    #1;
    tick();
    tick();
    chk("rst.drv_en", drv_en_a, 1'b1);
    chk("rst.gnt", gnt_a, 3'b000);

    // Write after reset: direction change forces one turnaround cycle.
    reset = 1'b0; req = 3'b001; wr = 3'b001; wdata = 48'h0000_0000_A5A5;
    tick(); chk("w1.turn_gnt", gnt_a, 3'b000); chk("w1.turn_busy", busy_a, 1'b1);
    tick(); chk("w1.x1_gnt", gnt_a, 3'b001); chk("w1.x1_tn", drv_tn_a, 1'b1);
    chk("w1.x1_en", drv_en_a, 1'b0); chk("w1.x1_a", drv_a_a, 16'hA5A5);
    tick(); chk("w1.x2_gnt", gnt_a, 3'b001);
    tick(); chk("w1.done", done_a, 3'b001); chk("w1.done_gnt", gnt_a, 3'b000);

    // Read by requester 1 right after the write.
    req = 3'b010; wr = 3'b000; drv_zi = 16'h1234;
    tick(); chk("r1.turn_gnt", gnt_a, 3'b000);
    tick(); chk("r1.x1_gnt", gnt_a, 3'b010); chk("r1.x1_en", drv_en_a, 1'b1);
    chk("r1.x1_tn", drv_tn_a, 1'b0);
    tick();
    tick(); chk("r1.done", done_a, 3'b010); chk("r1.rdata", rdata_a, 16'h1234);
    req = 3'b000;

    // All three reading continuously: plain round robin, no turnaround.
    reset = 1'b1;
    tick();
    reset = 1'b0; req = 3'b111; wr = 3'b000; drv_zi = 16'h0F0F;
    for (int g = 0; g < 4; g++) begin
      tick(); chk("rr.x1_gnt", gnt_a, oh(g % 3));
      tick(); chk("rr.x2_gnt", gnt_a, oh(g % 3));
      tick(); chk("rr.done", done_a, oh(g % 3)); chk("rr.done_gnt", gnt_a, 3'b000);
    end

    // Requester 2 write; wdata changes and req drops during XFER.
    req = 3'b100; wr = 3'b100; wdata = 48'hBEEF_0000_0000;
    tick(); chk("w2.turn_gnt", gnt_a, 3'b000);
    tick(); chk("w2.x1_gnt", gnt_a, 3'b100); chk("w2.x1_a", drv_a_a, 16'hBEEF);
    wdata = '0; req = 3'b000;
    tick(); chk("w2.x2_a", drv_a_a, 16'hBEEF); chk("w2.x2_tn", drv_tn_a, 1'b1);
    tick(); chk("w2.done", done_a, 3'b100); chk("w2.rdata_kept", rdata_a, 16'h0F0F);

    // Reset in the first XFER cycle of a write aborts it.
    req = 3'b001; wr = 3'b001; wdata = 48'h0000_0000_1111;
    tick(); chk("ab.x1_tn", drv_tn_a, 1'b1);
    reset = 1'b1; req = 3'b000;
    tick(); chk("ab.tn", drv_tn_a, 1'b0); chk("ab.en", drv_en_a, 1'b1);
    chk("ab.gnt", gnt_a, 3'b000); chk("ab.done", done_a, 3'b000);
    reset = 1'b0;
    tick(); chk("ab.no_done", done_a, 3'b000);
    req = 3'b111; wr = 3'b000;
    tick(); chk("ab.fresh_gnt", gnt_a, 3'b001);
    tick();
    tick(); chk("ab.fresh_done", done_a, 3'b001);
    req = 3'b000;

    // Alternating directions on the zero-turnaround instance.
    reset = 1'b1;
    tick();
    reset = 1'b0; req = 3'b001; wr = 3'b001; wdata = 48'h0000_0000_2222;
    tick(); chk("t0.x1_gnt", gnt_b, 3'b001); chk("t0.x1_tn", drv_tn_b, 1'b1);
    tick(); chk("t0.x2_gnt", gnt_b, 3'b001);
    tick(); chk("t0.done", done_b, 3'b001); chk("t0.idle", busy_b, 1'b0);
    req = 3'b010; wr = 3'b000; drv_zi = 16'h5A5A;
    tick(); chk("t0.r_gnt", gnt_b, 3'b010); chk("t0.r_en", drv_en_b, 1'b1);
    tick();
    tick(); chk("t0.r_done", done_b, 3'b010); chk("t0.rdata", rdata_b, 16'h5A5A);
    req = 3'b000;

    // Randomised traffic with occasional resets.
    for (int r = 0; r < 400; r++) begin
      req    = 3'($urandom_range(0, 7));
      wr     = 3'($urandom_range(0, 7));
      wdata  = 48'({$urandom(), $urandom()});
      drv_zi = 16'($urandom_range(0, 65535));
      reset  = ($urandom_range(0, 63) == 0);
      tick();
    end
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
